// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
// Default width/reset values live here so all blocks agree on them.
package ifu_prefetch_pkg;

  localparam int          IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam int          INST_BYTES   = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ifu_state_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch bus: valid/ready request channel plus an in-order response channel.
// A request transfers on a cycle where req_valid & req_ready are both high;
// req_valid may drop or req_addr change before acceptance (non-committing);
// rsp_valid carries one word per cycle, always in request order, never stalled.
interface ifu_prefetch_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; push while full is accepted
// only when a pop happens in the same cycle. Flush overrides push and pop.
module ifu_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with decoupled prefetch queue: credit-limited bus
// requests, in-order responses, redirect flush with stale-response discard.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic              wb_exp_int_flag,
  input  logic [XLEN-1:0]   meh_addr,
  input  logic              ex_is_mret_inst,
  input  logic [XLEN-1:0]   mret_addr,
  input  logic              bj_flag,
  input  logic [XLEN-1:0]   bj_addr,
  input  logic              pipe_stall,
  ifu_prefetch_if.master    bus,
  output logic              if_vld,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_inst,
  output logic              if_exp_flag,
  output logic              if_inst_addr_misal,
  output ifu_state_e        dbg_state
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam int            EW      = 2 * XLEN + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] OUT_MAX = '1;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [CW:0]     credit;
  logic            aligned, hs, rsp_keep, rsp_drop, misal_push;

  logic            q_push, q_pop, q_empty, q_full;
  logic [EW-1:0]   q_push_data, q_head;
  logic [CW-1:0]   count;

  logic            pc_push, pc_empty, pc_full;
  logic [XLEN-1:0] pc_head;
  logic [CW-1:0]   pc_count;

  assign redirect = wb_exp_int_flag | ex_is_mret_inst | bj_flag;

  always_comb begin
    target = bj_addr;
    if (wb_exp_int_flag)      target = meh_addr;
    else if (ex_is_mret_inst) target = mret_addr;
  end

  // Credits cover queued entries plus live (non-dropped) in-flight requests.
  // outst also counts stale requests, so it is kept from wrapping.
  assign credit  = {1'b0, count} + {1'b0, outst_q} - {1'b0, drop_q};
  assign aligned = is_word_aligned(fetch_pc_q[1:0]);

  assign bus.req_valid = if_valid & (state_q == ST_RUN) & aligned &
                         (credit < DEPTH_C) & (outst_q != OUT_MAX);
  assign bus.req_addr  = fetch_pc_q;

  assign hs         = bus.req_valid & bus.req_ready;
  assign rsp_drop   = bus.rsp_valid & (drop_q != '0);
  assign rsp_keep   = bus.rsp_valid & (drop_q == '0) & ~redirect;
  assign misal_push = (state_q == ST_RUN) & if_valid & ~aligned &
                      (outst_q == drop_q) & (count < CW'(DEPTH)) & ~redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + CW'(hs) - CW'(bus.rsp_valid);
    drop_d     = drop_q - CW'(rsp_drop);
    if (redirect) begin
      state_d    = ST_RUN;
      fetch_pc_d = target;
      drop_d     = outst_d;
    end else begin
      if (hs)         fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (misal_push) state_d    = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  assign q_push      = rsp_keep | misal_push;
  assign q_push_data = rsp_keep ? {pc_head, bus.rsp_data, 1'b0}
                                : {fetch_pc_q, {XLEN{1'b0}}, 1'b1};
  assign q_pop       = if_vld & ~pipe_stall;

  ifu_fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_entry_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .pop_data  (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (count)
  );

  // Only live requests get a PC slot; stale responses never need one.
  assign pc_push = hs & ~redirect;

  ifu_fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (pc_push),
    .push_data (fetch_pc_q),
    .pop       (rsp_keep),
    .pop_data  (pc_head),
    .empty     (pc_empty),
    .full      (pc_full),
    .count     (pc_count)
  );

  assign if_vld             = ~q_empty;
  assign if_pc              = if_vld ? q_head[EW-1 -: XLEN] : '0;
  assign if_inst            = if_vld ? q_head[XLEN:1]       : '0;
  assign if_inst_addr_misal = if_vld & q_head[0];
  assign if_exp_flag        = if_inst_addr_misal;
  assign dbg_state          = state_q;

  a_no_q_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && q_full && !q_pop));
  a_no_pc_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pc_push && pc_full));
  a_pc_has_entry: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && pc_empty));
  a_pc_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    pc_count == outst_q - drop_q);

endmodule
